// File: rtl/rr_preempt_timer.sv
// Round-robin preemption timer: counts user instructions after jimset and raises a
// one-cycle interrupt when the quantum loaded by setTimer has been consumed.
module rr_preempt_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             FLAG_timer,
    input  logic [WIDTH-1:0] quantum,
    input  logic             FLAG_IMoffset,
    input  logic             FLAG_biosim,
    input  logic             halt,
    output logic             interrupt,
    output logic             busy,
    output logic [WIDTH-1:0] remaining,
    output logic [15:0]      preempt_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_RUN    = 2'd2,
        ST_FIRE   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_reg_q, q_reg_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [15:0]      preempt_count_q, preempt_count_d;
    logic [WIDTH-1:0] count_inc_s;
    logic [WIDTH-1:0] remaining_s;

    assign count_inc_s = count_q + {{(WIDTH-1){1'b0}}, 1'b1};

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            q_reg_q         <= {WIDTH{1'b0}};
            count_q         <= {WIDTH{1'b0}};
            preempt_count_q <= 16'd0;
        end else begin
            state_q         <= state_d;
            q_reg_q         <= q_reg_d;
            count_q         <= count_d;
            preempt_count_q <= preempt_count_d;
        end
    end

    // Next-state logic; biosim outranks everything, FIRE swallows the other flags.
    always_comb begin
        state_d = state_q;
        q_reg_d = q_reg_q;
        count_d = count_q;
        if (state_q == ST_FIRE) begin
            preempt_count_d = preempt_count_q + 16'd1;
        end else begin
            preempt_count_d = preempt_count_q;
        end

        if (FLAG_biosim) begin
            state_d = ST_IDLE;
            count_d = {WIDTH{1'b0}};
        end else if (state_q == ST_FIRE) begin
            state_d = ST_LOADED;
            count_d = {WIDTH{1'b0}};
        end else if (FLAG_timer) begin
            count_d = {WIDTH{1'b0}};
            if (quantum == {WIDTH{1'b0}}) begin
                state_d = ST_IDLE;
            end else begin
                q_reg_d = quantum;
                if (FLAG_IMoffset || (state_q == ST_RUN)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_LOADED;
                end
            end
        end else if (FLAG_IMoffset && (state_q == ST_LOADED)) begin
            state_d = ST_RUN;
            count_d = {WIDTH{1'b0}};
        end else if ((state_q == ST_RUN) && !halt) begin
            // count never reaches q_reg: the last instruction of the slice goes to FIRE.
            if (count_inc_s == q_reg_q) begin
                state_d = ST_FIRE;
                count_d = {WIDTH{1'b0}};
            end else begin
                count_d = count_inc_s;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Instructions left in the current slice, only meaningful while armed.
    always_comb begin
        if ((state_q == ST_RUN) || (state_q == ST_LOADED)) begin
            remaining_s = q_reg_q - count_q;
        end else begin
            remaining_s = {WIDTH{1'b0}};
        end
    end

    assign interrupt     = (state_q == ST_FIRE);
    assign busy          = (state_q == ST_RUN);
    assign remaining     = remaining_s;
    assign preempt_count = preempt_count_q;

endmodule

// File: tb/tb_rr_preempt_timer.sv
// Directed self-checking bench for rr_preempt_timer: one task per scenario,
// expected values computed by hand from the slice timing rules.
module tb_rr_preempt_timer;

    logic        clock;
    logic        reset;
    logic        FLAG_timer;
    logic [31:0] quantum;
    logic        FLAG_IMoffset;
    logic        FLAG_biosim;
    logic        halt;
    logic        interrupt;
    logic        busy;
    logic [31:0] remaining;
    logic [15:0] preempt_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_pc = 16'd0;

    rr_preempt_timer #(.WIDTH(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .FLAG_timer    (FLAG_timer),
        .quantum       (quantum),
        .FLAG_IMoffset (FLAG_IMoffset),
        .FLAG_biosim   (FLAG_biosim),
        .halt          (halt),
        .interrupt     (interrupt),
        .busy          (busy),
        .remaining     (remaining),
        .preempt_count (preempt_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_flags();
        FLAG_timer    = 1'b0;
        FLAG_IMoffset = 1'b0;
        FLAG_biosim   = 1'b0;
        halt          = 1'b0;
        quantum       = 32'd0;
    endtask

    // Ticks until interrupt is seen (bounded); n == max_cycles means it never came.
    task automatic wait_fire(input int max_cycles, output int n);
        n = 0;
        while ((interrupt !== 1'b1) && (n < max_cycles)) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        FLAG_timer = 1'b1; FLAG_IMoffset = 1'b1; FLAG_biosim = 1'b1; halt = 1'b1;
        quantum = 32'd5;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ((interrupt !== 1'b0) || (busy !== 1'b0) || (remaining !== 32'd0) || (preempt_count !== 16'd0)) begin
                errors++;
                $display("FAIL reset_hold: int=%b busy=%b rem=%0d pc=%0d, want 0 0 0 0", interrupt, busy, remaining, preempt_count);
            end
        end
        clear_flags();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_slice();
        int n;
        FLAG_timer = 1'b1; quantum = 32'd5;
        tick();
        clear_flags();
        checks++;
        if ((busy !== 1'b0) || (remaining !== 32'd5)) begin
            errors++;
            $display("FAIL basic_loaded: busy=%b rem=%0d, want 0 5", busy, remaining);
        end
        tick();
        FLAG_IMoffset = 1'b1;
        tick();
        clear_flags();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ((busy !== 1'b1) || (remaining !== 32'(5 - i)) || (interrupt !== 1'b0)) begin
                errors++;
                $display("FAIL basic_run[%0d]: busy=%b rem=%0d int=%b, want 1 %0d 0", i, busy, remaining, interrupt, 5 - i);
            end
            tick();
        end
        checks++;
        if ((interrupt !== 1'b1) || (busy !== 1'b0) || (remaining !== 32'd0)) begin
            errors++;
            $display("FAIL basic_fire: int=%b busy=%b rem=%0d, want 1 0 0", interrupt, busy, remaining);
        end
        tick();
        exp_pc = exp_pc + 16'd1;
        checks++;
        if ((interrupt !== 1'b0) || (preempt_count !== exp_pc) || (remaining !== 32'd5) || (busy !== 1'b0)) begin
            errors++;
            $display("FAIL basic_after: int=%b pc=%0d rem=%0d busy=%b, want 0 %0d 5 0", interrupt, preempt_count, remaining, busy, exp_pc);
        end
        n = 0;
    endtask

    task automatic test_halt_freeze();
        int n;
        FLAG_timer = 1'b1; quantum = 32'd4;
        tick();
        clear_flags();
        FLAG_IMoffset = 1'b1;
        tick();
        clear_flags();
        tick();
        tick();
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ((remaining !== 32'd2) || (busy !== 1'b1)) begin
                errors++;
                $display("FAIL halt_hold[%0d]: rem=%0d busy=%b, want 2 1", i, remaining, busy);
            end
        end
        halt = 1'b0;
        wait_fire(20, n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL halt_fire_delay: cycles=%0d, want 2 (7 from slice start)", n);
        end
        tick();
        exp_pc = exp_pc + 16'd1;
        checks++;
        if (preempt_count !== exp_pc) begin
            errors++;
            $display("FAIL halt_pc: pc=%0d, want %0d", preempt_count, exp_pc);
        end
    endtask

    task automatic test_reload();
        int n;
        FLAG_IMoffset = 1'b1;
        tick();
        clear_flags();
        tick();
        tick();
        checks++;
        if (remaining !== 32'd2) begin
            errors++;
            $display("FAIL reload_pre: rem=%0d, want 2", remaining);
        end
        FLAG_timer = 1'b1; quantum = 32'd10;
        tick();
        clear_flags();
        checks++;
        if ((remaining !== 32'd10) || (busy !== 1'b1)) begin
            errors++;
            $display("FAIL reload_restart: rem=%0d busy=%b, want 10 1", remaining, busy);
        end
        wait_fire(30, n);
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL reload_fire_delay: cycles=%0d, want 10", n);
        end
        tick();
        exp_pc = exp_pc + 16'd1;
        checks++;
        if ((preempt_count !== exp_pc) || (remaining !== 32'd10)) begin
            errors++;
            $display("FAIL reload_after: pc=%0d rem=%0d, want %0d 10", preempt_count, remaining, exp_pc);
        end
    endtask

    task automatic test_biosim_cancel();
        int n;
        FLAG_IMoffset = 1'b1;
        tick();
        clear_flags();
        tick();
        FLAG_biosim = 1'b1;
        tick();
        clear_flags();
        checks++;
        if ((busy !== 1'b0) || (remaining !== 32'd0)) begin
            errors++;
            $display("FAIL biosim_idle: busy=%b rem=%0d, want 0 0", busy, remaining);
        end
        FLAG_IMoffset = 1'b1;
        tick();
        clear_flags();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL biosim_jimset: busy=%b, want 0", busy);
        end
        wait_fire(15, n);
        checks++;
        if ((n != 15) || (preempt_count !== exp_pc)) begin
            errors++;
            $display("FAIL biosim_no_irq: cycles=%0d pc=%0d, want 15 %0d", n, preempt_count, exp_pc);
        end
    endtask

    task automatic test_zero_and_reslice();
        int n;
        FLAG_timer = 1'b1; quantum = 32'd3;
        tick();
        FLAG_timer = 1'b1; quantum = 32'd0;
        tick();
        clear_flags();
        checks++;
        if ((remaining !== 32'd0) || (busy !== 1'b0)) begin
            errors++;
            $display("FAIL zero_idle: rem=%0d busy=%b, want 0 0", remaining, busy);
        end
        FLAG_IMoffset = 1'b1;
        tick();
        clear_flags();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_jimset: busy=%b, want 0", busy);
        end
        FLAG_timer = 1'b1; quantum = 32'd3;
        tick();
        clear_flags();
        FLAG_IMoffset = 1'b1;
        tick();
        clear_flags();
        wait_fire(20, n);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL reslice_first: cycles=%0d, want 3", n);
        end
        tick();
        exp_pc = exp_pc + 16'd1;
        FLAG_IMoffset = 1'b1;
        tick();
        clear_flags();
        checks++;
        if ((busy !== 1'b1) || (remaining !== 32'd3)) begin
            errors++;
            $display("FAIL reslice_start: busy=%b rem=%0d, want 1 3", busy, remaining);
        end
        wait_fire(20, n);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL reslice_second: cycles=%0d, want 3", n);
        end
        // Flags during FIRE are overridden by the PC_so jump.
        FLAG_timer = 1'b1; quantum = 32'd7; FLAG_IMoffset = 1'b1;
        tick();
        clear_flags();
        exp_pc = exp_pc + 16'd1;
        checks++;
        if ((busy !== 1'b0) || (remaining !== 32'd3) || (preempt_count !== exp_pc)) begin
            errors++;
            $display("FAIL fire_ignores_flags: busy=%b rem=%0d pc=%0d, want 0 3 %0d", busy, remaining, preempt_count, exp_pc);
        end
    endtask

    task automatic one_unit_slice();
        FLAG_IMoffset = 1'b1;
        tick();
        clear_flags();
        tick();
        checks++;
        if (interrupt !== 1'b1) begin
            errors++;
            $display("FAIL unit_slice_fire: int=%b, want 1", interrupt);
        end
        tick();
    endtask

    task automatic test_wrap();
        FLAG_timer = 1'b1; quantum = 32'd1;
        tick();
        clear_flags();
        for (int i = 0; i < 20; i++) begin
            one_unit_slice();
        end
        exp_pc = exp_pc + 16'd20;
        checks++;
        if (preempt_count !== exp_pc) begin
            errors++;
            $display("FAIL wrap_count: pc=%0d, want %0d", preempt_count, exp_pc);
        end
        force dut.preempt_count_q = 16'hFFFE;
        #1;
        release dut.preempt_count_q;
        one_unit_slice();
        checks++;
        if (preempt_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_ffff: pc=%h, want ffff", preempt_count);
        end
        one_unit_slice();
        checks++;
        if (preempt_count !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_zero: pc=%h, want 0000", preempt_count);
        end
    endtask

    task automatic test_async_reset();
        FLAG_timer = 1'b1; quantum = 32'd1; FLAG_IMoffset = 1'b1;
        tick();
        clear_flags();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL areset_run: busy=%b, want 1", busy);
        end
        tick();
        checks++;
        if (interrupt !== 1'b1) begin
            errors++;
            $display("FAIL areset_fire: int=%b, want 1", interrupt);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ((interrupt !== 1'b0) || (busy !== 1'b0) || (preempt_count !== 16'd0) || (remaining !== 32'd0)) begin
            errors++;
            $display("FAIL areset_drop: int=%b busy=%b pc=%0d rem=%0d, want 0 0 0 0", interrupt, busy, preempt_count, remaining);
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ((interrupt !== 1'b0) || (preempt_count !== 16'd0)) begin
                errors++;
                $display("FAIL areset_quiet[%0d]: int=%b pc=%0d, want 0 0", i, interrupt, preempt_count);
            end
        end
    endtask

    initial begin
        clear_flags();
        reset = 1'b0;
        test_reset();
        test_basic_slice();
        test_halt_freeze();
        test_reload();
        test_biosim_cancel();
        test_zero_and_reslice();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
